reglog_master: RTL and testbench
================================

Name: reglog_master

Overview:
- Initiator for the 6 x 16-bit register-log file. The file has a combinational read and writes on the clock edge when reglog_wren=1.
- Accepts single register commands on a valid/ready command channel: read, write, add, and clear-bits.
- Sequences the file's reglog_addr/reglog_wren/reglog_in pins and samples reglog_out.
- Returns one response per command on a valid/ready response channel. Sits between control logic and the register file.

Parameters:
- ADDR_W, 3, width of cmd_addr and reglog_addr.
- MAX_ADDR, 5, highest implemented register index. Any index above this is an error.
- DATA_W, 16, register data width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_op  input  2  00 READ, 01 WRITE, 10 ADD, 11 CLR.
- cmd_addr  input  ADDR_W  target register index.
- cmd_data  input  DATA_W  write data, addend, or clear mask.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  DATA_W  response data.
- rsp_err  output  1  address out of range.
- reglog_addr  output  ADDR_W  register file address, registered.
- reglog_wren  output  1  register file write enable, registered.
- reglog_in  output  DATA_W  register file write data, registered.
- reglog_out  input  DATA_W  register file combinational read data.

Behaviour:
- Reset values: FSM=IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, reglog_addr=0, reglog_wren=0, reglog_in=0.
- Reset takes effect asynchronously: reglog_wren drops immediately, any in-flight command is dropped, and no response is produced for it.
- FSM states: IDLE, RD, WR, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready (cycle T), latch op, addr, and data.
  - addr>MAX_ADDR: go to RESP with rsp_err=1, rsp_data=0. No register-file access, reglog_wren stays 0.
  - WRITE: go to WR with reglog_addr=addr, reglog_in=cmd_data.
  - READ/ADD/CLR: go to RD with reglog_addr=addr.
- RD (cycle T+1): sample reglog_out into old.
  - READ: go to RESP with rsp_data=old.
  - ADD: go to WR with reglog_in=old+cmd_data (mod 2^DATA_W, carry discarded).
  - CLR: go to WR with reglog_in=old & ~cmd_data.
- WR: reglog_wren=1 for exactly this one cycle, then go to RESP.
  - rsp_data = written value for WRITE; old value for ADD and CLR.
  - reglog_addr and reglog_in are stable throughout WR.
- RESP: rsp_valid=1. rsp_data and rsp_err are held stable until rsp_valid&&rsp_ready. On that handshake, rsp_valid=0 next cycle and return to IDLE.
- Latency from command accept to first rsp_valid cycle:
  - error: 1 cycle.
  - READ or WRITE: 2 cycles.
  - ADD or CLR: 3 cycles.
- Backpressure: rsp_ready low holds the FSM in RESP indefinitely. cmd_ready stays 0, so no new command is accepted until the response handshake completes. Never more than one command in flight.
- reglog_addr retains its last value outside RD/WR. reglog_wren is 0 in every state except WR.
- rsp_err clears to 0 on the next non-error response.

Optional Feature:
- Macro: REGLOG_MASTER_SAT_EN.
- Defined: ADD saturates; if old+cmd_data overflows DATA_W, the value written is all ones (16'hFFFF).
- Undefined: ADD wraps modulo 2^DATA_W.
- All other ops and all timing are identical in both builds.

Test Plan:
- Reset, then WRITE addr=2 data=16'hA5A5 with rsp_ready=1 -> reglog_wren high one cycle (cycle T+1) with reglog_addr=2, reglog_in=A5A5; rsp_valid at T+2, rsp_data=A5A5, rsp_err=0.
- READ addr=2 after the write -> rsp_valid at T+2, rsp_data=A5A5, reglog_wren never asserted.
- Reg3=16'hFFF0, ADD addr=3 data=16'h0020 -> non-SAT build writes 0010; SAT build writes FFFF. rsp_data=FFF0 (old) at T+3.
- Reg1=16'h00FF, CLR addr=1 mask=16'h000F -> writes 00F0, rsp_data=00FF. Then READ addr=7 -> rsp_valid at T+1, rsp_err=1, rsp_data=0, no wren.
- Hold rsp_ready=0 for 5 cycles after a READ -> rsp_valid and rsp_data stable, cmd_ready=0, a pending cmd_valid not accepted until the handshake.
- Assert reset during the RD cycle of an ADD -> reglog_wren never pulses, rsp_valid=0, cmd_ready=1 after reset release, target register unchanged.

Source files
------------

// File: rtl/reglog_master.sv
// reglog_master: single-command initiator for the 6x16 register-log file; define REGLOG_MASTER_SAT_EN for saturating ADD.
// Latency accept->rsp_valid: 1 cycle on address error, 2 for READ/WRITE, 3 for ADD/CLR.
// Backpressure: one command in flight; cmd_ready only in IDLE, RESP held until rsp_ready.
module reglog_master #(
  parameter int ADDR_W   = 3,
  parameter int MAX_ADDR = 5,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] reglog_addr,
  output logic              reglog_wren,
  output logic [DATA_W-1:0] reglog_in,
  input  logic [DATA_W-1:0] reglog_out
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] reglog_addr_q, reglog_addr_d;
  logic              reglog_wren_q, reglog_wren_d;
  logic [DATA_W-1:0] reglog_in_q, reglog_in_d;

  logic              cmd_fire;
  logic              rsp_fire;
  logic              addr_bad;
  logic [DATA_W-1:0] add_res;
  logic [DATA_W-1:0] clr_res;

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign reglog_addr = reglog_addr_q;
  assign reglog_wren = reglog_wren_q;
  assign reglog_in   = reglog_in_q;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign rsp_fire = rsp_valid && rsp_ready;
  assign addr_bad = (int'(cmd_addr) > MAX_ADDR);

  // Read-modify-write results are formed from the live file output during RD.
`ifdef REGLOG_MASTER_SAT_EN
  logic [DATA_W:0] add_sum;
  assign add_sum = {1'b0, reglog_out} + {1'b0, data_q};
  assign add_res = add_sum[DATA_W] ? {DATA_W{1'b1}} : add_sum[DATA_W-1:0];
`else
  assign add_res = reglog_out + data_q;
`endif
  assign clr_res = reglog_out & ~data_q;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    data_d        = data_q;
    old_d         = old_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    reglog_addr_d = reglog_addr_q;
    reglog_wren_d = 1'b0;
    reglog_in_d   = reglog_in_q;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          if (addr_bad) begin
            state_d    = RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else if (cmd_op == OP_WRITE) begin
            state_d       = WR;
            reglog_addr_d = cmd_addr;
            reglog_in_d   = cmd_data;
            reglog_wren_d = 1'b1;
          end else begin
            state_d       = RD;
            reglog_addr_d = cmd_addr;
          end
        end
      end

      RD: begin
        old_d = reglog_out;
        case (op_q)
          OP_ADD: begin
            state_d       = WR;
            reglog_in_d   = add_res;
            reglog_wren_d = 1'b1;
          end
          OP_CLR: begin
            state_d       = WR;
            reglog_in_d   = clr_res;
            reglog_wren_d = 1'b1;
          end
          default: begin
            state_d    = RESP;
            rsp_data_d = reglog_out;
            rsp_err_d  = 1'b0;
          end
        endcase
      end

      WR: begin
        state_d    = RESP;
        rsp_err_d  = 1'b0;
        rsp_data_d = (op_q == OP_WRITE) ? reglog_in_q : old_q;
      end

      RESP: begin
        if (rsp_fire) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      op_q          <= OP_READ;
      data_q        <= '0;
      old_q         <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      reglog_addr_q <= '0;
      reglog_wren_q <= 1'b0;
      reglog_in_q   <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      data_q        <= data_d;
      old_q         <= old_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      reglog_addr_q <= reglog_addr_d;
      reglog_wren_q <= reglog_wren_d;
      reglog_in_q   <= reglog_in_d;
    end
  end

endmodule

// File: tb/tb_reglog_master.sv
// Bench for reglog_master: behavioural register file, abstract per-command model, directed and random commands.
module tb_reglog_master;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [2:0]  cmd_addr = 3'd0;
  logic [15:0] cmd_data = 16'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [2:0]  reglog_addr;
  logic        reglog_wren;
  logic [15:0] reglog_in;
  logic [15:0] reglog_out;

  logic [15:0] regs [0:5];
  logic [15:0] mdl  [0:5];

  int          cyc = 0;
  int          wren_cnt = 0;
  int          wren_cyc = 0;
  logic [2:0]  wren_addr = 3'd0;
  logic [15:0] wren_dat = 16'h0;
  int          rv_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  reglog_master #(.ADDR_W(3), .MAX_ADDR(5), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .reglog_addr(reglog_addr), .reglog_wren(reglog_wren), .reglog_in(reglog_in),
    .reglog_out(reglog_out)
  );

  always #5 clk = ~clk;

  // The 6 x 16 file: combinational read, write on the rising edge.
  assign reglog_out = (reglog_addr <= 3'd5) ? regs[reglog_addr] : 16'h0;
  always @(posedge clk) begin
    if (reglog_wren && reglog_addr <= 3'd5) regs[reglog_addr] <= reglog_in;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (reglog_wren) begin
      wren_cnt  = wren_cnt + 1;
      wren_cyc  = cyc;
      wren_addr = reglog_addr;
      wren_dat  = reglog_in;
    end
    if (rsp_valid) rv_cnt = rv_cnt + 1;
  end

  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'(a) + int'(b);
`ifdef REGLOG_MASTER_SAT_EN
    if (s > 65535) return 16'hFFFF;
`endif
    return 16'(s % 65536);
  endfunction

  // Drives one command with rsp_ready=1 and reports what was observed; latency -1 means timeout.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] a, input logic [15:0] d,
                         output logic [15:0] r_dat, output logic r_err, output int lat,
                         output int wr_n, output int wr_lat, output logic [2:0] wr_a,
                         output logic [15:0] wr_d);
    int t_acc, w0, k;
    @(negedge clk);
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1; rsp_ready = 1'b1;
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    t_acc = cyc; w0 = wren_cnt;
    @(posedge clk); #1 cmd_valid = 1'b0;
    lat = -1; r_dat = 16'hxxxx; r_err = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = cyc - t_acc; r_dat = rsp_data; r_err = rsp_err; break; end
    end
    @(posedge clk); #1;
    wr_n = wren_cnt - w0; wr_lat = wren_cyc - t_acc; wr_a = wren_addr; wr_d = wren_dat;
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    n_chk++; if (rsp_data !== 16'h0) begin n_fail++; $display("FAIL rst_rsp_data got=%h exp=0000", rsp_data); end
    n_chk++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
    n_chk++; if (reglog_addr !== 3'd0) begin n_fail++; $display("FAIL rst_addr got=%0d exp=0", reglog_addr); end
    n_chk++; if (reglog_wren !== 1'b0) begin n_fail++; $display("FAIL rst_wren got=%b exp=0", reglog_wren); end
    n_chk++; if (reglog_in !== 16'h0) begin n_fail++; $display("FAIL rst_in got=%h exp=0000", reglog_in); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write();
    logic [15:0] rd, wd; logic re; logic [2:0] wa; int lat, wn, wl;
    run_cmd(OP_WRITE, 3'd2, 16'hA5A5, rd, re, lat, wn, wl, wa, wd);
    mdl[2] = 16'hA5A5;
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL wr_latency got=%0d exp=2", lat); end
    n_chk++; if (rd !== 16'hA5A5 || re !== 1'b0) begin n_fail++; $display("FAIL wr_rsp got=%h/%b exp=a5a5/0", rd, re); end
    n_chk++; if (wn != 1 || wl != 1) begin n_fail++; $display("FAIL wr_wren_pulse got=%0d@%0d exp=1@1", wn, wl); end
    n_chk++; if (wa !== 3'd2 || wd !== 16'hA5A5) begin n_fail++; $display("FAIL wr_wren_bus got=%0d/%h exp=2/a5a5", wa, wd); end
  endtask

  task automatic test_read();
    logic [15:0] rd, wd; logic re; logic [2:0] wa; int lat, wn, wl;
    run_cmd(OP_READ, 3'd2, 16'h1234, rd, re, lat, wn, wl, wa, wd);
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL rd_latency got=%0d exp=2", lat); end
    n_chk++; if (rd !== mdl[2] || re !== 1'b0) begin n_fail++; $display("FAIL rd_rsp got=%h/%b exp=%h/0", rd, re, mdl[2]); end
    n_chk++; if (wn != 0) begin n_fail++; $display("FAIL rd_no_wren got=%0d exp=0", wn); end
  endtask

  task automatic test_add();
    logic [15:0] rd, wd, exp_w; logic re; logic [2:0] wa; int lat, wn, wl;
    run_cmd(OP_WRITE, 3'd3, 16'hFFF0, rd, re, lat, wn, wl, wa, wd);
    mdl[3] = 16'hFFF0;
`ifdef REGLOG_MASTER_SAT_EN
    exp_w = 16'hFFFF;
`else
    exp_w = 16'h0010;
`endif
    run_cmd(OP_ADD, 3'd3, 16'h0020, rd, re, lat, wn, wl, wa, wd);
    mdl[3] = exp_w;
    n_chk++; if (lat != 3) begin n_fail++; $display("FAIL add_latency got=%0d exp=3", lat); end
    n_chk++; if (rd !== 16'hFFF0 || re !== 1'b0) begin n_fail++; $display("FAIL add_rsp got=%h/%b exp=fff0/0", rd, re); end
    n_chk++; if (wn != 1 || wl != 2 || wa !== 3'd3 || wd !== exp_w) begin n_fail++; $display("FAIL add_write got=%0d@%0d a=%0d d=%h exp=1@2 a=3 d=%h", wn, wl, wa, wd, exp_w); end
    n_chk++; if (regs[3] !== exp_w) begin n_fail++; $display("FAIL add_file got=%h exp=%h", regs[3], exp_w); end
  endtask

  task automatic test_clr_err();
    logic [15:0] rd, wd; logic re; logic [2:0] wa; int lat, wn, wl;
    run_cmd(OP_WRITE, 3'd1, 16'h00FF, rd, re, lat, wn, wl, wa, wd);
    run_cmd(OP_CLR, 3'd1, 16'h000F, rd, re, lat, wn, wl, wa, wd);
    mdl[1] = 16'h00F0;
    n_chk++; if (lat != 3 || rd !== 16'h00FF) begin n_fail++; $display("FAIL clr_rsp got=%h lat=%0d exp=00ff lat=3", rd, lat); end
    n_chk++; if (wn != 1 || wa !== 3'd1 || wd !== 16'h00F0) begin n_fail++; $display("FAIL clr_write got=%0d a=%0d d=%h exp=1 a=1 d=00f0", wn, wa, wd); end
    run_cmd(OP_READ, 3'd7, 16'hFFFF, rd, re, lat, wn, wl, wa, wd);
    n_chk++; if (lat != 1) begin n_fail++; $display("FAIL err_latency got=%0d exp=1", lat); end
    n_chk++; if (rd !== 16'h0 || re !== 1'b1) begin n_fail++; $display("FAIL err_rsp got=%h/%b exp=0000/1", rd, re); end
    n_chk++; if (wn != 0) begin n_fail++; $display("FAIL err_no_wren got=%0d exp=0", wn); end
    run_cmd(OP_READ, 3'd1, 16'h0, rd, re, lat, wn, wl, wa, wd);
    n_chk++; if (rd !== 16'h00F0 || re !== 1'b0) begin n_fail++; $display("FAIL err_clears got=%h/%b exp=00f0/0", rd, re); end
  endtask

  task automatic test_backpressure();
    int t_acc, lat, w0, k;
    @(negedge clk);
    rsp_ready = 1'b0; cmd_op = OP_READ; cmd_addr = 3'd2; cmd_data = 16'h0; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    t_acc = cyc; w0 = wren_cnt;
    @(posedge clk); #1;
    cmd_op = OP_WRITE; cmd_addr = 3'd0; cmd_data = 16'hBEEF;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = cyc - t_acc; break; end
    end
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL bp_latency got=%0d exp=2", lat); end
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_data !== mdl[2] || cmd_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold cyc%0d got v=%b d=%h rdy=%b exp v=1 d=%h rdy=0", i, rsp_valid, rsp_data, cmd_ready, mdl[2]); end
      @(negedge clk);
    end
    n_chk++; if (wren_cnt != w0) begin n_fail++; $display("FAIL bp_pending_taken got=%0d exp=0", wren_cnt - w0); end
    rsp_ready = 1'b1;
    k = 0;
    while (wren_cnt == w0 && k < 20) begin @(negedge clk); k++; end
    cmd_valid = 1'b0;
    mdl[0] = 16'hBEEF;
    n_chk++; if (wren_cnt - w0 != 1 || wren_addr !== 3'd0 || wren_dat !== 16'hBEEF)
      begin n_fail++; $display("FAIL bp_pending_write got=%0d a=%0d d=%h exp=1 a=0 d=beef", wren_cnt - w0, wren_addr, wren_dat); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midcmd();
    logic [15:0] rd, wd; logic re; logic [2:0] wa; int lat, wn, wl, w0, r0;
    run_cmd(OP_WRITE, 3'd4, 16'h1234, rd, re, lat, wn, wl, wa, wd);
    mdl[4] = 16'h1234;
    // ADD interrupted in its RD cycle
    @(negedge clk);
    cmd_op = OP_ADD; cmd_addr = 3'd4; cmd_data = 16'h0101; cmd_valid = 1'b1;
    w0 = wren_cnt; r0 = rv_cnt;
    @(posedge clk); #1 cmd_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_chk++; if (reglog_wren !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
      begin n_fail++; $display("FAIL rst_rd_async got wren=%b v=%b rdy=%b exp 0/0/1", reglog_wren, rsp_valid, cmd_ready); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    n_chk++; if (wren_cnt != w0 || rv_cnt != r0 || cmd_ready !== 1'b1)
      begin n_fail++; $display("FAIL rst_rd_after got wren=%0d rsp=%0d rdy=%b exp 0/0/1", wren_cnt - w0, rv_cnt - r0, cmd_ready); end
    n_chk++; if (regs[4] !== 16'h1234) begin n_fail++; $display("FAIL rst_rd_file got=%h exp=1234", regs[4]); end
    // WRITE interrupted while wren is high
    @(negedge clk);
    cmd_op = OP_WRITE; cmd_addr = 3'd0; cmd_data = 16'h5A5A; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    n_chk++; if (reglog_wren !== 1'b1) begin n_fail++; $display("FAIL rst_wr_pre got=%b exp=1", reglog_wren); end
    #2 reset = 1'b1;
    #1;
    n_chk++; if (reglog_wren !== 1'b0) begin n_fail++; $display("FAIL rst_wr_drop got=%b exp=0", reglog_wren); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (regs[0] !== mdl[0]) begin n_fail++; $display("FAIL rst_wr_file got=%h exp=%h", regs[0], mdl[0]); end
    run_cmd(OP_READ, 3'd4, 16'h0, rd, re, lat, wn, wl, wa, wd);
    n_chk++; if (rd !== 16'h1234 || lat != 2) begin n_fail++; $display("FAIL rst_readback got=%h lat=%0d exp=1234 lat=2", rd, lat); end
  endtask

  task automatic test_random();
    logic [15:0] rd, wd, d, e_dat, e_wd; logic re, e_err, e_wr; logic [2:0] wa, a;
    logic [1:0] op; int lat, wn, wl, e_lat, e_wl;
    for (int n = 0; n < 80; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = 3'($urandom_range(0, 7));
      d  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d = 16'hFF00 | 16'($urandom_range(0, 255));
      e_err = (a > 3'd5); e_wr = 1'b0; e_wd = 16'h0; e_wl = 0; e_dat = 16'h0; e_lat = 1;
      if (!e_err) begin
        case (op)
          OP_READ:  begin e_dat = mdl[a]; e_lat = 2; end
          OP_WRITE: begin e_dat = d; e_lat = 2; e_wr = 1'b1; e_wd = d; e_wl = 1; end
          OP_ADD:   begin e_dat = mdl[a]; e_lat = 3; e_wr = 1'b1; e_wd = ref_add(mdl[a], d); e_wl = 2; end
          default:  begin e_dat = mdl[a]; e_lat = 3; e_wr = 1'b1; e_wd = mdl[a] & ~d; e_wl = 2; end
        endcase
      end
      run_cmd(op, a, d, rd, re, lat, wn, wl, wa, wd);
      if (e_wr) mdl[a] = e_wd;
      n_chk++; if (rd !== e_dat || re !== e_err || lat != e_lat)
        begin n_fail++; $display("FAIL rnd%0d_rsp op=%0d a=%0d got=%h/%b/%0d exp=%h/%b/%0d", n, op, a, rd, re, lat, e_dat, e_err, e_lat); end
      n_chk++; if (wn != (e_wr ? 1 : 0) || (e_wr && (wa !== a || wd !== e_wd || wl != e_wl)))
        begin n_fail++; $display("FAIL rnd%0d_wren op=%0d got n=%0d a=%0d d=%h @%0d exp n=%0d a=%0d d=%h @%0d", n, op, wn, wa, wd, wl, e_wr, a, e_wd, e_wl); end
    end
    for (int i = 0; i < 6; i++) begin
      n_chk++; if (regs[i] !== mdl[i]) begin n_fail++; $display("FAIL rnd_file[%0d] got=%h exp=%h", i, regs[i], mdl[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      regs[i] = 16'(i * 16'h1111);
      mdl[i]  = 16'(i * 16'h1111);
    end
    test_reset();
    test_write();
    test_read();
    test_add();
    test_clr_err();
    test_backpressure();
    test_reset_midcmd();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
